// File: rtl/alu_flags_seq.sv
// Sequential ALU with registered {V,N,C,Z} flags and an iterative one-bit-per-cycle
// shifter behind a start/busy/done handshake.
module alu_flags_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   flags_load_i,
  input  logic [3:0]             flags_d_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic [3:0]             flags_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_INV = 4'h7,
    OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB,
    OP_CMP = 4'hC, OP_RSD = 4'hD, OP_RSE = 4'hE, OP_RSF = 4'hF
  } op_t;

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [3:0]              flags_q, flags_nx;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   b_eff;
  logic                    cin;
  logic [DATA_WIDTH:0]     sum;
  logic                    ovf;
  logic [DATA_WIDTH-1:0]   logic_res;
  logic [DATA_WIDTH-1:0]   shift_res;
  logic                    shift_out;

  // Subtraction is a + ~b + carry-in, so C=1 reads as "no borrow".
  always_comb begin
    b_eff = b_q;
    cin   = 1'b0;
    case (op_q)
      OP_ADC:         cin = flags_q[1];
      OP_SUB, OP_CMP: begin b_eff = ~b_q; cin = 1'b1; end
      OP_SBC:         begin b_eff = ~b_q; cin = flags_q[1]; end
      default:        ;
    endcase
    sum = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};
    ovf = (a_q[MSB] == b_eff[MSB]) && (sum[MSB] != a_q[MSB]);
  end

  always_comb begin
    logic_res = a_q;
    case (op_q)
      OP_AND:  logic_res = a_q & b_q;
      OP_OR:   logic_res = a_q | b_q;
      OP_XOR:  logic_res = a_q ^ b_q;
      OP_INV:  logic_res = ~a_q;
      default: ;
    endcase
  end

  // a_q doubles as the working shift register while in SHIFT.
  always_comb begin
    shift_res = a_q;
    shift_out = 1'b0;
    case (op_q)
      OP_SHL:  begin shift_res = {a_q[MSB-1:0], 1'b0};     shift_out = a_q[MSB]; end
      OP_SHR:  begin shift_res = {1'b0, a_q[MSB:1]};       shift_out = a_q[0];   end
      OP_ASR:  begin shift_res = {a_q[MSB], a_q[MSB:1]};   shift_out = a_q[0];   end
      OP_ROL:  begin shift_res = {a_q[MSB-1:0], a_q[MSB]}; shift_out = a_q[MSB]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_nx = flags_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_t'(op_i);
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = shamt_i;
          state_d = (op_i[3:2] == 2'b10 && shamt_i != '0) ? SHIFT : EXEC;
        end else if (flags_load_i) begin
          flags_nx = flags_d_i;
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        case (op_q)
          OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            result_d = sum[MSB:0];
            flags_nx = {ovf, sum[MSB], sum[DATA_WIDTH], sum[MSB:0] == '0};
          end
          OP_CMP:
            flags_nx = {ovf, sum[MSB], sum[DATA_WIDTH], sum[MSB:0] == '0};
          OP_AND, OP_OR, OP_XOR, OP_INV: begin
            result_d = logic_res;
            flags_nx = {1'b0, logic_res[MSB], flags_q[1], logic_res == '0};
          end
          OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
            result_d = a_q;
            flags_nx = {1'b0, a_q[MSB], flags_q[1], a_q == '0};
          end
          default: ;
        endcase
      end
      SHIFT: begin
        a_d   = shift_res;
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = shift_res;
          flags_nx = {1'b0, shift_res[MSB], shift_out, shift_res == '0};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_nx;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_flags_seq.sv
// Bench for alu_flags_seq: an arithmetic reference model checked against the 8-bit DUT every
// cycle, plus directed vectors with literal expectations on both widths.
module tb_alu_flags_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, fl_load = 1'b0;
  logic [3:0] op = '0, fl_d = '0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] shamt = '0;
  logic [7:0] res8;
  logic [3:0] flg8;
  logic       busy8, done8;

  logic        start16 = 1'b0, fl_load16 = 1'b0;
  logic [3:0]  op16 = '0, fl_d16 = '0, shamt16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  flg16;
  logic        busy16, done16;

  alu_flags_seq #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .shamt_i(shamt), .flags_load_i(fl_load), .flags_d_i(fl_d),
    .result_o(res8), .flags_o(flg8), .busy_o(busy8), .done_o(done8)
  );

  alu_flags_seq #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start_i(start16), .op_i(op16), .a_i(a16), .b_i(b16),
    .shamt_i(shamt16), .flags_load_i(fl_load16), .flags_d_i(fl_d16),
    .result_o(res16), .flags_o(flg16), .busy_o(busy16), .done_o(done16)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] lat;
  } mres_t;

  // Reference: signed/unsigned integer arithmetic over a w-bit word, flags {V,N,C,Z}.
  function automatic mres_t model_op(input int w, input int opc, input int av, input int bv,
                                     input int sh, input int r_in, input logic [3:0] f_in);
    mres_t m;
    int mask, half, sa, sb, full, sv, rr, ci, c;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (av >= half) ? av - (1 << w) : av;
    sb = (bv >= half) ? bv - (1 << w) : bv;
    m.r = r_in; m.f = f_in; m.lat = 1;
    case (opc)
      0, 1: begin
        ci = (opc == 1) ? int'(f_in[1]) : 0;
        full = av + bv + ci;
        sv = sa + sb + ci;
        rr = full & mask;
        m.r = rr;
        m.f[3] = (sv >= half) || (sv < -half);
        m.f[2] = rr >= half;
        m.f[1] = full > mask;
        m.f[0] = rr == 0;
      end
      2, 3, 12: begin
        ci = (opc == 3) ? 1 - int'(f_in[1]) : 0;
        full = av - bv - ci;
        sv = sa - sb - ci;
        rr = full & mask;
        if (opc != 12) m.r = rr;
        m.f[3] = (sv >= half) || (sv < -half);
        m.f[2] = rr >= half;
        m.f[1] = full >= 0;
        m.f[0] = rr == 0;
      end
      4, 5, 6, 7: begin
        case (opc)
          4: rr = av & bv;
          5: rr = av | bv;
          6: rr = av ^ bv;
          default: rr = (~av) & mask;
        endcase
        m.r = rr;
        m.f[3] = 1'b0; m.f[2] = rr >= half; m.f[1] = f_in[1]; m.f[0] = rr == 0;
      end
      8, 9, 10, 11: begin
        rr = av;
        c = int'(f_in[1]);
        for (int k = 0; k < sh; k++) begin
          case (opc)
            8:  begin c = (rr >> (w - 1)) & 1; rr = (rr << 1) & mask; end
            9:  begin c = rr & 1; rr = rr >> 1; end
            10: begin c = rr & 1; rr = (rr >> 1) | (rr & half); end
            default: begin c = (rr >> (w - 1)) & 1; rr = ((rr << 1) & mask) | c; end
          endcase
        end
        m.r = rr;
        m.f[3] = 1'b0; m.f[2] = rr >= half; m.f[1] = c[0]; m.f[0] = rr == 0;
        if (sh > 0) m.lat = sh;
      end
      default: ;
    endcase
    return m;
  endfunction

  // Cycle-level timeline of the 8-bit unit driven by the same inputs.
  bit         armed = 1'b0;
  int         m_result = 0, m_left = 0;
  logic [3:0] m_flags = '0;
  bit         m_done = 1'b0;
  mres_t      pend;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0; m_done <= 1'b0; m_result <= 0; m_flags <= '0; armed <= 1'b1;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (start) begin
        pend   <= model_op(8, int'(op), int'(a), int'(b), int'(shamt), m_result, m_flags);
        m_left <= (op >= 4'h8 && op <= 4'hB && shamt != 0) ? int'(shamt) : 1;
      end else if (fl_load) begin
        m_flags <= fl_d;
      end
    end else if (m_left == 1) begin
      m_result <= int'(pend.r);
      m_flags  <= pend.f;
      m_done   <= 1'b1;
      m_left   <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_busy",   32'(busy8), 32'(m_left != 0));
      chk("cyc_done",   32'(done8), 32'(m_done));
      chk("cyc_result", 32'(res8),  m_result);
      chk("cyc_flags",  32'(flg8),  32'(m_flags));
    end
  end

  task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] sh, input logic ld, input logic [7:0] er,
                      input logic [3:0] ef, input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; shamt = sh; fl_load = ld; fl_d = 4'hF;
    @(negedge clk);
    start = 1'b0; fl_load = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_res"}, 32'(res8), 32'(er));
    chk({nm, "_flg"}, 32'(flg8), 32'(ef));
    chk({nm, "_mdl_res"}, m_result, 32'(er));
    chk({nm, "_mdl_flg"}, 32'(m_flags), 32'(ef));
  endtask

  task automatic run16(input string nm, input logic [3:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] er, input logic [3:0] ef);
    int n;
    @(negedge clk);
    start16 = 1'b1; op16 = o; a16 = av; b16 = bv;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (done16 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_res"}, 32'(res16), 32'(er));
    chk({nm, "_flg"}, 32'(flg16), 32'(ef));
  endtask

  initial begin
    int n;
    bit saw;
    mres_t t;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_res", 32'(res8), 0);
    chk("rst_flg", 32'(flg8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);

    t = model_op(16, 0, 'h7FFF, 1, 0, 0, 4'h0);
    chk("pin16_add_r", t.r, 32'h8000);
    chk("pin16_add_f", 32'(t.f), 32'hC);

    run8("add_ff01",  4'h0, 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 4'b0011, 1);
    run8("sub_0507",  4'h2, 8'h05, 8'h07, 3'd0, 1'b0, 8'hFE, 4'b0100, 1);
    run8("sbc_1000",  4'h3, 8'h10, 8'h00, 3'd0, 1'b0, 8'h0F, 4'b0010, 1);
    run8("add_7f01",  4'h0, 8'h7F, 8'h01, 3'd0, 1'b0, 8'h80, 4'b1100, 1);

    @(negedge clk); fl_load = 1'b1; fl_d = 4'b0010;
    @(negedge clk); fl_load = 1'b0;
    chk("load_flg", 32'(flg8), 32'h2);

    run8("adc_0000",  4'h1, 8'h00, 8'h00, 3'd0, 1'b0, 8'h01, 4'b0000, 1);
    run8("shl_81_3",  4'h8, 8'h81, 8'h00, 3'd3, 1'b0, 8'h08, 4'b0000, 3);
    run8("rol_81_1",  4'hB, 8'h81, 8'h00, 3'd1, 1'b0, 8'h03, 4'b0010, 1);
    run8("and",       4'h4, 8'hF0, 8'h3C, 3'd0, 1'b0, 8'h30, 4'b0010, 1);
    run8("xor_zero",  4'h6, 8'hAA, 8'hAA, 3'd0, 1'b0, 8'h00, 4'b0011, 1);
    run8("inv",       4'h7, 8'h00, 8'h00, 3'd0, 1'b0, 8'hFF, 4'b0110, 1);
    run8("asr_80_2",  4'hA, 8'h80, 8'h00, 3'd2, 1'b0, 8'hE0, 4'b0100, 2);
    run8("cmp_8001",  4'hC, 8'h80, 8'h01, 3'd0, 1'b0, 8'hE0, 4'b1010, 1);
    run8("or_zero",   4'h5, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 4'b0011, 1);
    run8("rsvd_d",    4'hD, 8'h55, 8'h55, 3'd0, 1'b0, 8'h00, 4'b0011, 1);
    run8("shr_sh0",   4'h9, 8'h01, 8'h00, 3'd0, 1'b0, 8'h01, 4'b0010, 1);
    run8("sbc_0001",  4'h3, 8'h00, 8'h01, 3'd0, 1'b0, 8'hFF, 4'b0100, 1);
    run8("adc_8080",  4'h1, 8'h80, 8'h80, 3'd0, 1'b0, 8'h00, 4'b1011, 1);
    run8("add_ldign", 4'h0, 8'h01, 8'h01, 3'd0, 1'b1, 8'h02, 4'b0000, 1);

    // start and flags_load re-asserted while busy must both be ignored
    @(negedge clk); start = 1'b1; op = 4'h9; a = 8'hF0; shamt = 3'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = 4'h0; a = 8'h01; b = 8'h01; shamt = 3'd0;
    fl_load = 1'b1; fl_d = 4'hF;
    @(negedge clk); start = 1'b0; fl_load = 1'b0;
    n = 2;
    while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("shr_poke_lat", n, 4);
    chk("shr_poke_res", 32'(res8), 32'h0F);
    chk("shr_poke_flg", 32'(flg8), 32'h0);
    @(negedge clk);
    chk("shr_poke_idle", 32'(busy8), 0);

    // reset in the middle of a long shift
    start = 1'b1; op = 4'h8; a = 8'hFF; shamt = 3'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    chk("midrst_res", 32'(res8), 0);
    chk("midrst_flg", 32'(flg8), 0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); saw |= (done8 === 1'b1); end
    chk("midrst_no_done", 32'(saw), 0);

    run16("w16_add", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100);
    run16("w16_cmp", 4'hC, 16'h1234, 16'h1234, 16'h8000, 4'b0011);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
